// File: rtl/flash_master_pkg.sv
// Shared opcodes, frame geometry and state encoding for the SPI flash read master.
package flash_master_pkg;

  localparam logic [7:0] OP_READ = 8'h03;
  localparam logic [7:0] OP_RPD  = 8'hAB;

  localparam int FRAME_BITS = 64;
  localparam int INIT_BITS  = 8;
  localparam int DATA_START = 32;

  typedef logic [2:0] state_t;
  localparam state_t ST_INIT_CMD  = 3'd0;
  localparam state_t ST_INIT_WAIT = 3'd1;
  localparam state_t ST_IDLE      = 3'd2;
  localparam state_t ST_XFER      = 3'd3;
  localparam state_t ST_GAP       = 3'd4;

  // Flash returns bytes in ascending address order; first byte lands in the low lane.
  function automatic logic [31:0] byte_swap(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/flash_master.sv
// SPI mode-0 flash read master: wakes the part with 0xAB, then serves 32-bit reads via 0x03.
module flash_master
  import flash_master_pkg::*;
#(
  parameter int WAKE_CYCLES     = 3000,
  parameter int CSN_HIGH_CYCLES = 2
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  output logic        ready_o,
  input  logic        req_i,
  input  logic [23:0] addr_i,
  output logic        ack_o,
  output logic [31:0] data_o,
  output logic        flash_csn,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_wpn,
  output logic        flash_holdn
);

  localparam int XFER_LEN = 2 * FRAME_BITS + 1;
  localparam int CNT_MAX  = (WAKE_CYCLES > XFER_LEN) ?
                            ((WAKE_CYCLES > CSN_HIGH_CYCLES) ? WAKE_CYCLES : CSN_HIGH_CYCLES) :
                            ((XFER_LEN > CSN_HIGH_CYCLES) ? XFER_LEN : CSN_HIGH_CYCLES);
  localparam int CNT_W    = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] XFER_END   = CNT_W'(XFER_LEN);
  localparam logic [CNT_W-1:0] INIT_END   = CNT_W'(2 * INIT_BITS + 1);
  localparam logic [CNT_W-1:0] SAMP_FIRST = CNT_W'(2 * DATA_START + 3);
  localparam logic [CNT_W-1:0] WAKE_LAST  = CNT_W'(WAKE_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(CSN_HIGH_CYCLES - 1);

  state_t           state;
  logic [63:0]      sr;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             frame_end;
  logic             samp_bit;
  logic             start_rd;
  logic             unused_addr;

  assign flash_wpn   = 1'b1;
  assign flash_holdn = 1'b1;
  assign unused_addr = ^addr_i[1:0];

  // cnt counts clk edges since flash_csn fell: odd values open a low phase, even values a high phase.
  always_comb begin
    cnt_nxt   = cnt + 1'b1;
    frame_end = (state == ST_XFER) ? (cnt_nxt == XFER_END) : (cnt_nxt == INIT_END);
    samp_bit  = flash_miso && (state == ST_XFER) && (cnt_nxt >= SAMP_FIRST);
    start_rd  = req_i && ((state == ST_IDLE) || ((state == ST_GAP) && (cnt == GAP_LAST)));
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state      <= ST_INIT_CMD;
      sr         <= {OP_RPD, 56'h0};
      cnt        <= '0;
      flash_csn  <= 1'b1;
      flash_clk  <= 1'b0;
      flash_mosi <= 1'b0;
      ack_o      <= 1'b0;
      ready_o    <= 1'b0;
      data_o     <= '0;
    end else begin
      ack_o <= 1'b0;
      case (state)
        ST_INIT_CMD, ST_XFER: begin
          if ((state == ST_INIT_CMD) && flash_csn) begin
            flash_csn  <= 1'b0;
            flash_mosi <= sr[63];
            cnt        <= '0;
          end else begin
            cnt <= cnt_nxt;
            if (frame_end) begin
              flash_csn  <= 1'b1;
              flash_clk  <= 1'b0;
              flash_mosi <= 1'b0;
              cnt        <= '0;
              if (state == ST_XFER) begin
                ack_o  <= 1'b1;
                data_o <= byte_swap({sr[30:0], flash_miso});
                state  <= ST_GAP;
              end else begin
                state <= ST_INIT_WAIT;
              end
            end else if (!cnt_nxt[0]) begin
              flash_clk <= 1'b1;
            end else begin
              flash_clk <= 1'b0;
              // Falling edge: capture the bit the flash presented, present the next one.
              if (cnt_nxt != CNT_W'(1)) begin
                sr         <= {sr[62:0], samp_bit};
                flash_mosi <= sr[62];
              end
            end
          end
        end
        ST_INIT_WAIT: begin
          cnt <= cnt_nxt;
          if (cnt == WAKE_LAST) begin
            ready_o <= 1'b1;
            state   <= ST_IDLE;
            cnt     <= '0;
          end
        end
        ST_GAP: begin
          cnt <= cnt_nxt;
          if (cnt == GAP_LAST) state <= ST_IDLE;
        end
        ST_IDLE: ;
        default: state <= ST_INIT_CMD;
      endcase

      if (start_rd) begin
        sr         <= {OP_READ, addr_i[23:2], 2'b00, 32'h0};
        state      <= ST_XFER;
        cnt        <= '0;
        flash_csn  <= 1'b0;
        flash_clk  <= 1'b0;
        flash_mosi <= OP_READ[7];
      end
    end
  end

endmodule
